wbs_dma_csr: RTL and testbench
==============================

WBS_DMA_CSR -- requirements
Module: wbs_dma_csr

Interface
REQ-001 Parameters: NCH, 2, channel count (1..4).
REQ-002 Parameters: SEL_BIT, 10, wbs_adr_i bit that must be 1 for a valid access.
REQ-003 Clock and reset are fixed: one clock; reset is asynchronous and active-high (wb_clk_i, wb_rst_i).
REQ-004 Ports (name  direction  width  meaning):
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  async active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone slave cycle, strobe, write.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  registered read data.
- wbs_ack_o, wbs_err_o  out  1  terminate pulses.
- wbs_rty_o  out  1  constant 0.
- enable, append  out  NCH  per-channel control bits.
- append_clear  in  NCH  clear pulse from the DMA engine.
- ndar  out  NCH*29  next descriptor address [31:3] per channel.
- ndar_dirty  out  NCH  NDAR written, not yet consumed.
- ndar_dirty_clear  in  NCH  consume pulse.
- dar  in  NCH*32  current descriptor address.
- busy  in  NCH  channel busy.
- done_i  in  NCH  one-cycle completion event.
- irq_o  out  1  registered combined interrupt.

Function
REQ-005 Decode: channel = adr[6:5], register = adr[4:2].
- Registers: 0 CCR (b0 append, b1 enable, b2 write-only "clear pending"); 1 STAT RO {busy, pending}; 2 DAR RO; 3 NDAR {ndar,3'b0}; 4 IMR b0 mask; 5 ISR b0 pending, b1 overflow, W1C.
REQ-006 The access SHALL be terminated with err instead of ack when any of these hold: adr[SEL_BIT]=0, channel>=NCH, register 6 or 7.
- Error accesses change no state and return wbs_dat_o=0.
REQ-007 Handshake: when cyc&stb are high and no termination was issued in the previous cycle, exactly one of ack or err SHALL pulse high for one cycle, on the next clock edge.
- Read data is registered on that same edge.
- Write state commits on that same edge.
- Back-to-back strobes therefore terminate every second cycle.
REQ-008 Writes SHALL apply only to bytes whose wbs_sel_i bit is set.
- CCR and IMR live in byte 0.
- NDAR bits [7:3] are in byte 0.
REQ-009 An NDAR write SHALL take effect only when that channel's enable=0; otherwise it is ignored but still acked.
- A taken NDAR write sets ndar_dirty.
REQ-010 ndar_dirty: set by a taken NDAR write, cleared by ndar_dirty_clear; a write in the same cycle wins.
REQ-011 append: loaded by a CCR write, cleared by append_clear; a write in the same cycle wins.
REQ-012 pending: set by done_i, cleared by an ISR W1C bit0 or CCR b2; set wins over clear in the same cycle.
REQ-013 overflow: set when done_i arrives while pending=1, cleared by ISR W1C bit1.
REQ-014 irq_o SHALL be registered as the OR over channels of (pending & ~mask), giving one cycle of latency after the pending change.
REQ-015 Read fields narrower than 32 bits SHALL be zero-extended.
REQ-016 Inputs of channels >= NCH do not exist; all per-channel logic SHALL be generated for NCH channels.

Reset
REQ-017 Asynchronous assertion of wb_rst_i SHALL drive to 0: wbs_ack_o, wbs_err_o, wbs_dat_o, enable, append, ndar, ndar_dirty, IMR, pending, overflow, irq_o.
REQ-018 Reset mid-cycle SHALL abort any termination.
- The first termination after release occurs one edge after cyc&stb is sampled high.

Verification
REQ-019 Write CCR ch1 data 0x3, sel 0x1 -> ack one cycle later; enable[1]=1, append[1]=1; channel 0 unchanged.
REQ-020 enable[0]=1, write NDAR ch0 0x1000 -> acked, ndar[0] unchanged, ndar_dirty[0]=0.
- Then enable[0]=0, write 0x1008 -> ndar[0]=0x201, ndar_dirty[0]=1.
- ndar_dirty_clear pulse -> 0.
REQ-021 done_i[0] pulse, mask 0 -> pending=1 and irq_o=1 one cycle later.
- A second done_i -> overflow=1.
- ISR write 0x3 concurrent with done_i -> pending=1, overflow=0.
REQ-022 NCH=2, read adr with adr[6:5]=3 or register 6 -> wbs_err_o pulse, wbs_ack_o=0, data 0.
- An access with adr[SEL_BIT]=0 -> err.
REQ-023 CCR write append=1 in the same cycle as append_clear -> append=1; a later append_clear alone -> 0.
REQ-024 Assert wb_rst_i while a strobe is pending with ack about to rise -> all outputs 0 immediately, no ack; after release the strobe is acked on the next edge.

Source files
------------

// File: rtl/wbs_dma_csr.sv
// Wishbone slave register file for a multi-channel DMA engine: per-channel control,
// descriptor pointers and interrupt status, plus a registered combined interrupt.
module wbs_dma_csr #(
    parameter int NCH     = 2,
    parameter int SEL_BIT = 10
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic [31:0]          wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o,
    output logic                 wbs_rty_o,
    output logic [NCH-1:0]       enable,
    output logic [NCH-1:0]       append,
    input  logic [NCH-1:0]       append_clear,
    output logic [NCH*29-1:0]    ndar,
    output logic [NCH-1:0]       ndar_dirty,
    input  logic [NCH-1:0]       ndar_dirty_clear,
    input  logic [NCH*32-1:0]    dar,
    input  logic [NCH-1:0]       busy,
    input  logic [NCH-1:0]       done_i,
    output logic                 irq_o
);

    localparam logic [2:0] R_CCR  = 3'd0;
    localparam logic [2:0] R_STAT = 3'd1;
    localparam logic [2:0] R_DAR  = 3'd2;
    localparam logic [2:0] R_NDAR = 3'd3;
    localparam logic [2:0] R_IMR  = 3'd4;
    localparam logic [2:0] R_ISR  = 3'd5;

    logic [1:0]     w_ch;
    logic [2:0]     w_reg;
    logic           w_access;
    logic           w_valid;
    logic           w_wr;
    logic [31:0]    w_rdata;
    logic           w_unused;

    logic           r_ack;
    logic           r_err;
    logic [31:0]    r_dat;
    logic           r_irq;

    logic [NCH-1:0] w_enable;
    logic [NCH-1:0] w_append;
    logic [NCH-1:0] w_dirty;
    logic [NCH-1:0] w_mask;
    logic [NCH-1:0] w_pending;
    logic [NCH-1:0] w_overflow;
    logic [28:0]    w_ndar [NCH];

    assign w_ch     = wbs_adr_i[6:5];
    assign w_reg    = wbs_adr_i[4:2];
    // a termination in the previous cycle blocks a new one, so held strobes alternate
    assign w_access = wbs_cyc_i & wbs_stb_i & ~(r_ack | r_err);
    assign w_valid  = wbs_adr_i[SEL_BIT] && (int'(w_ch) < NCH) && (w_reg <= R_ISR);
    assign w_wr     = w_access & w_valid & wbs_we_i;
    assign w_unused = ^wbs_adr_i;

    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (int'(w_ch) == c) begin
                case (w_reg)
                    R_CCR:   w_rdata = {30'd0, w_enable[c], w_append[c]};
                    R_STAT:  w_rdata = {30'd0, busy[c], w_pending[c]};
                    R_DAR:   w_rdata = dar[c*32 +: 32];
                    R_NDAR:  w_rdata = {w_ndar[c], 3'b000};
                    R_IMR:   w_rdata = {31'd0, w_mask[c]};
                    R_ISR:   w_rdata = {30'd0, w_overflow[c], w_pending[c]};
                    default: w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_access & w_valid;
            r_err <= w_access & ~w_valid;
            if (w_access)
                r_dat <= (w_valid & ~wbs_we_i) ? w_rdata : 32'd0;
            r_irq <= |(w_pending & ~w_mask);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic        w_hit;
        logic        w_ccr_wr;
        logic        w_ndar_wr;
        logic        w_imr_wr;
        logic        w_isr_wr;
        logic        w_pend_clr;
        logic [28:0] w_ndar_next;
        logic        r_enable;
        logic        r_append;
        logic        r_dirty;
        logic        r_mask;
        logic        r_pending;
        logic        r_overflow;
        logic [28:0] r_ndar;

        assign w_hit      = w_wr & (int'(w_ch) == c);
        assign w_ccr_wr   = w_hit & (w_reg == R_CCR) & wbs_sel_i[0];
        assign w_imr_wr   = w_hit & (w_reg == R_IMR) & wbs_sel_i[0];
        assign w_isr_wr   = w_hit & (w_reg == R_ISR) & wbs_sel_i[0];
        // NDAR may only move while the channel is stopped
        assign w_ndar_wr  = w_hit & (w_reg == R_NDAR) & ~r_enable & (|wbs_sel_i);
        assign w_pend_clr = (w_isr_wr & wbs_dat_i[0]) | (w_ccr_wr & wbs_dat_i[2]);

        assign w_ndar_next = {wbs_sel_i[3] ? wbs_dat_i[31:24] : r_ndar[28:21],
                              wbs_sel_i[2] ? wbs_dat_i[23:16] : r_ndar[20:13],
                              wbs_sel_i[1] ? wbs_dat_i[15:8]  : r_ndar[12:5],
                              wbs_sel_i[0] ? wbs_dat_i[7:3]   : r_ndar[4:0]};

        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                r_enable   <= 1'b0;
                r_append   <= 1'b0;
                r_dirty    <= 1'b0;
                r_mask     <= 1'b0;
                r_pending  <= 1'b0;
                r_overflow <= 1'b0;
                r_ndar     <= '0;
            end else begin
                if (w_ccr_wr) begin
                    r_enable <= wbs_dat_i[1];
                    r_append <= wbs_dat_i[0];
                end else if (append_clear[c]) begin
                    r_append <= 1'b0;
                end

                if (w_ndar_wr) begin
                    r_ndar  <= w_ndar_next;
                    r_dirty <= 1'b1;
                end else if (ndar_dirty_clear[c]) begin
                    r_dirty <= 1'b0;
                end

                if (w_imr_wr)
                    r_mask <= wbs_dat_i[0];

                if (done_i[c])
                    r_pending <= 1'b1;
                else if (w_pend_clr)
                    r_pending <= 1'b0;

                // an event that lands as software acknowledges the old one is not an overrun
                if (done_i[c] & r_pending & ~w_pend_clr)
                    r_overflow <= 1'b1;
                else if (w_isr_wr & wbs_dat_i[1])
                    r_overflow <= 1'b0;
            end
        end

        assign w_enable[c]         = r_enable;
        assign w_append[c]         = r_append;
        assign w_dirty[c]          = r_dirty;
        assign w_mask[c]           = r_mask;
        assign w_pending[c]        = r_pending;
        assign w_overflow[c]       = r_overflow;
        assign w_ndar[c]           = r_ndar;
        assign ndar[c*29 +: 29]    = r_ndar;
    end

    assign wbs_dat_o  = r_dat;
    assign wbs_ack_o  = r_ack;
    assign wbs_err_o  = r_err;
    assign wbs_rty_o  = 1'b0;
    assign enable     = w_enable;
    assign append     = w_append;
    assign ndar_dirty = w_dirty;
    assign irq_o      = r_irq;

endmodule

// File: tb/tb_wbs_dma_csr.sv
// Directed bench for wbs_dma_csr: bus responses go through an expectation queue,
// side-band state is checked directly against hand-derived values.
module tb_wbs_dma_csr;

    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]        sel = 4'h0;
    logic [31:0]       adr = '0, wdat = '0;
    logic [31:0]       dat_o;
    logic              ack, err, rty;
    logic [NCH-1:0]    enable, append, append_clear = '0;
    logic [NCH*29-1:0] ndar;
    logic [NCH-1:0]    ndar_dirty, ndar_dirty_clear = '0;
    logic [NCH*32-1:0] dar = '0;
    logic [NCH-1:0]    busy = '0, done = '0;
    logic              irq;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q [$];   // {ack, err, data}

    always #5 clk = ~clk;

    wbs_dma_csr #(.NCH(NCH), .SEL_BIT(10)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_dat_o(dat_o), .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty),
        .enable(enable), .append(append), .append_clear(append_clear),
        .ndar(ndar), .ndar_dirty(ndar_dirty), .ndar_dirty_clear(ndar_dirty_clear),
        .dar(dar), .busy(busy), .done_i(done), .irq_o(irq)
    );

    function automatic logic [31:0] A(input int ch, input int rg);
        return 32'h400 | 32'(ch << 5) | 32'(rg << 2);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus access; dn/ac pulses are applied on the same edge that commits the access.
    task automatic bus(input string tag, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_dat,
                       input logic [NCH-1:0] dn, input logic [NCH-1:0] ac);
        int n;
        logic [33:0] e;
        exp_q.push_back({~e_err, e_err, e_dat});
        cyc = 1; stb = 1; we = w; adr = a; sel = s; wdat = d;
        done = dn; append_clear = ac;
        n = 0;
        do begin
            @(posedge clk); #1;
            done = '0; append_clear = '0;
            n++;
        end while (!(ack | err) && n < 8);
        e = exp_q.pop_front();
        chk({tag, "_resp"}, {ack, err, dat_o}, e);
        chk({tag, "_lat"}, n, 1);
        cyc = 0; stb = 0; we = 0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_done(input logic [NCH-1:0] m);
        done = m;
        @(posedge clk); #1;
        done = '0;
    endtask

    initial begin
        int acks;
        #2;
        chk("rst_ack", {ack, err, rty}, 3'b000);
        chk("rst_dat", dat_o, 0);
        chk("rst_ctl", {enable, append, ndar_dirty, irq}, 0);
        chk("rst_ndar", ndar, 0);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        bus("ccr1_wr", 1, A(1, 0), 4'h1, 32'h3, 0, 0, 0, 0);
        chk("ccr1_en", enable, 2'b10);
        chk("ccr1_ap", append, 2'b10);
        bus("ccr1_rd", 0, A(1, 0), 4'hF, 0, 0, 32'h3, 0, 0);

        bus("ccr0_en", 1, A(0, 0), 4'h1, 32'h2, 0, 0, 0, 0);
        bus("ndar_lock", 1, A(0, 3), 4'hF, 32'h1000, 0, 0, 0, 0);
        chk("ndar_lock_val", ndar[28:0], 0);
        chk("ndar_lock_dirty", ndar_dirty, 2'b00);
        bus("ccr0_dis", 1, A(0, 0), 4'h1, 32'h0, 0, 0, 0, 0);
        bus("ndar_wr", 1, A(0, 3), 4'hF, 32'h1008, 0, 0, 0, 0);
        chk("ndar_val", ndar[28:0], 29'h201);
        chk("ndar_dirty", ndar_dirty, 2'b01);
        bus("ndar_byte1", 1, A(0, 3), 4'h2, 32'hFFFF_FFFF, 0, 0, 0, 0);
        bus("ndar_rd", 0, A(0, 3), 4'hF, 0, 0, 32'hFF08, 0, 0);
        ndar_dirty_clear = 2'b01;
        @(posedge clk); #1;
        ndar_dirty_clear = '0;
        chk("dirty_clr", ndar_dirty, 2'b00);

        pulse_done(2'b01);
        chk("irq_latency", irq, 0);
        @(posedge clk); #1;
        chk("irq_set", irq, 1);
        bus("isr_p", 0, A(0, 5), 4'hF, 0, 0, 32'h1, 0, 0);
        pulse_done(2'b01);
        bus("isr_ovf", 0, A(0, 5), 4'hF, 0, 0, 32'h3, 0, 0);
        bus("isr_w1c_done", 1, A(0, 5), 4'h1, 32'h3, 0, 0, 2'b01, 0);
        bus("isr_after", 0, A(0, 5), 4'hF, 0, 0, 32'h1, 0, 0);
        busy = 2'b01;
        bus("stat_rd", 0, A(0, 1), 4'hF, 0, 0, 32'h3, 0, 0);
        bus("isr_clr", 1, A(0, 5), 4'h1, 32'h1, 0, 0, 0, 0);
        chk("irq_clr", irq, 0);
        bus("imr_wr", 1, A(0, 4), 4'h1, 32'h1, 0, 0, 0, 0);
        pulse_done(2'b01);
        @(posedge clk); #1;
        chk("irq_masked", irq, 0);
        bus("imr_rd", 0, A(0, 4), 4'hF, 0, 0, 32'h1, 0, 0);
        bus("ccr_clrpend", 1, A(0, 0), 4'h1, 32'h4, 0, 0, 0, 0);
        bus("stat_clr", 0, A(0, 1), 4'hF, 0, 0, 32'h2, 0, 0);

        dar[63:32] = 32'hDEAD_BEEF;
        bus("dar_rd", 0, A(1, 2), 4'hF, 0, 0, 32'hDEAD_BEEF, 0, 0);
        bus("err_ch3", 0, A(3, 0), 4'hF, 0, 1, 0, 0, 0);
        bus("err_reg6", 0, A(0, 6), 4'hF, 0, 1, 0, 0, 0);
        bus("err_sel", 1, A(0, 0) & ~32'h400, 4'h1, 32'h3, 1, 0, 0, 0);
        chk("err_noeffect", enable, 2'b10);

        bus("app_vs_clr", 1, A(0, 0), 4'h1, 32'h1, 0, 0, 0, 2'b01);
        chk("app_win", append, 2'b11);
        append_clear = 2'b01;
        @(posedge clk); #1;
        append_clear = '0;
        chk("app_clr", append, 2'b10);

        cyc = 1; stb = 1; we = 0; adr = A(1, 0); sel = 4'hF;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 0; stb = 0;
        chk("b2b_acks", acks, 2);
        @(posedge clk); #1;

        cyc = 1; stb = 1; we = 0; adr = A(1, 0); sel = 4'hF;
        #4 rst = 1;
        #1;
        chk("midrst_out", {ack, err, irq, enable, append, ndar_dirty}, 0);
        chk("midrst_data", {ndar, dat_o}, 0);
        @(posedge clk); #1;
        chk("midrst_hold", {ack, err}, 2'b00);
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst_ack", {ack, err, dat_o}, {2'b10, 32'h0});
        cyc = 0; stb = 0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
